// File: rtl/mips_hazard_sequencer.sv
// mips_hazard_sequencer: pipeline-register load/flush/bubble sequencing for the
// 5-stage MIPS core. It handles load-use stalls, EX-resolved redirects and
// data-memory wait states, with a timeout that releases the pipe and sets a
// sticky error flag.
// Optional build macro HAZ_PERF_CNT_EN adds stall_cnt and flush_cnt_tot
// performance counters as output ports.
module mips_hazard_sequencer #(
    parameter int unsigned FLUSH_DEPTH = 1,   // 1..7
    parameter int unsigned MEM_TIMEOUT = 255  // 1..255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  id_opcode,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        ex_memread,
    input  logic [4:0]  ex_wreg,
    input  logic [1:0]  ex_pcsrc,
    input  logic        mem_req,
    input  logic        mem_ack,
    output logic        pc_ld,
    output logic        ifid_ld,
    output logic        ifid_flush,
    output logic        idex_bubble,
    output logic        pipe_ld,
    output logic        memwb_bubble,
    output logic        mem_err,
`ifdef HAZ_PERF_CNT_EN
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt_tot,
`endif
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_FLUSH    = 2'b01,
        ST_MEM_WAIT = 2'b10
    } state_e;

    localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_DEPTH - 1);
    localparam logic [7:0] WAIT_LIMIT   = 8'(MEM_TIMEOUT);

    state_e     state_q, state_d;
    logic [2:0] flush_cnt_q, flush_cnt_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       mem_err_q, mem_err_d;

    logic rt_user, rs_user, lu_hit;
    logic mem_stall, redirect_go, lu_go;

    // Decode which ID source registers the instruction actually reads, and
    // the three hazard conditions in priority order.
    always_comb begin
        rt_user = (id_opcode inside {6'b000000, 6'b100000, 6'b101000, 6'b011101});
        rs_user = !(id_opcode inside {6'b010000, 6'b011000});
        lu_hit  = ex_memread && (ex_wreg != 5'd0) &&
                  ((rs_user && (ex_wreg == id_rs)) || (rt_user && (ex_wreg == id_rt)));
        // The timeout bound stops a stuck memory from freezing the pipe forever.
        mem_stall   = mem_req && !mem_ack && (wait_cnt_q < WAIT_LIMIT);
        redirect_go = !mem_stall && (state_q == ST_RUN) && (ex_pcsrc != 2'b00);
        lu_go       = !mem_stall && (state_q == ST_RUN) && (ex_pcsrc == 2'b00) && lu_hit;
    end

    // Output enables and next-state selection.
    always_comb begin
        // NOTE: every signal gets a default before the if-chain, so no path
        // leaves one unassigned and no latch is inferred.
        pc_ld        = 1'b1;
        ifid_ld      = 1'b1;
        ifid_flush   = 1'b0;
        idex_bubble  = 1'b0;
        pipe_ld      = 1'b1;
        memwb_bubble = 1'b0;
        state_d      = state_q;
        flush_cnt_d  = flush_cnt_q;
        wait_cnt_d   = wait_cnt_q;
        mem_err_d    = mem_err_q;

        if (mem_stall) begin
            // Freeze everything. A flush in progress keeps its remaining count.
            pc_ld        = 1'b0;
            ifid_ld      = 1'b0;
            pipe_ld      = 1'b0;
            memwb_bubble = 1'b1;
            state_d      = ST_MEM_WAIT;
            wait_cnt_d   = wait_cnt_q + 8'd1;
        end else if (state_q == ST_MEM_WAIT) begin
            // Release on ack or timeout, then resume any paused flush.
            wait_cnt_d = 8'd0;
            if (wait_cnt_q == WAIT_LIMIT) mem_err_d = 1'b1;
            state_d    = (flush_cnt_q != 3'd0) ? ST_FLUSH : ST_RUN;
        end else if (state_q == ST_FLUSH) begin
            // EX holds a bubble here, so ex_pcsrc is not looked at.
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            flush_cnt_d = (flush_cnt_q != 3'd0) ? flush_cnt_q - 3'd1 : 3'd0;
            state_d     = (flush_cnt_q <= 3'd1) ? ST_RUN : ST_FLUSH;
        end else begin
            // RUN, and recovery from the unused encoding.
            state_d = ST_RUN;
            if (redirect_go) begin
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
                flush_cnt_d = FLUSH_RELOAD;
                state_d     = (FLUSH_RELOAD != 3'd0) ? ST_FLUSH : ST_RUN;
            end else if (lu_go) begin
                pc_ld       = 1'b0;
                ifid_ld     = 1'b0;
                idex_bubble = 1'b1;
            end
        end

        // While reset is held, present the hazard-free RUN enables.
        if (!rst_n) begin
            pc_ld        = 1'b1;
            ifid_ld      = 1'b1;
            ifid_flush   = 1'b0;
            idex_bubble  = 1'b0;
            pipe_ld      = 1'b1;
            memwb_bubble = 1'b0;
        end
    end

    // State, flush/wait counters and the sticky error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            flush_cnt_q <= 3'd0;
            wait_cnt_q  <= 8'd0;
            mem_err_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so all registers update together
            // from the values held before this edge.
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_err_q   <= mem_err_d;
        end
    end

    assign mem_err = mem_err_q;
    assign state   = state_q;

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] stall_cnt_q, flush_tot_q;

    // Free-running, wrapping counts of stall cycles and accepted redirects.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= 32'd0;
            flush_tot_q <= 32'd0;
        end else begin
            if (mem_stall || lu_go) stall_cnt_q <= stall_cnt_q + 32'd1;
            if (redirect_go)        flush_tot_q <= flush_tot_q + 32'd1;
        end
    end

    assign stall_cnt     = stall_cnt_q;
    assign flush_cnt_tot = flush_tot_q;
`endif

endmodule
